trig_request_arbiter: RTL
=========================

Name: trig_request_arbiter

Overview:
- Shares one angle_normalizer → cordic → result_converter chain between two requesters, e.g. two processor ports.
- Sits between the requesters and the chain.
- Per job: accepts one IEEE754 angle from a requester, pulses it into the normalizer, waits for the chain's done, then returns the sin/cos result to the same requester.
- Provides round-robin fairness, a timeout watchdog and job/timeout statistics.

Parameters:
- TIMEOUT, 64: max cycles in WAIT before the job is aborted with an error. Must be ≥2.
- CNT_W, 16: width of the statistics counters.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  2  bit i: requester i has an angle pending
- req0_angle  in  32  IEEE754 angle from requester 0
- req1_angle  in  32  IEEE754 angle from requester 1
- req_ready  out  2  one-hot, 1-cycle acceptance pulse to the granted requester
- rsp_valid  out  2  one-hot; result available for requester i
- rsp_ready  in  2  bit i: requester i consumes the result
- rsp_sin  out  32  sin result, shared bus
- rsp_cos  out  32  cos result, shared bus
- rsp_err  out  1  result invalid (timeout); qualified by rsp_valid
- norm_valid  out  1  start request to angle_normalizer valid_in
- norm_angle  out  32  angle to angle_normalizer angle_in
- norm_ready  in  1  angle_normalizer ready
- chain_done  in  1  1-cycle done pulse from result_converter
- chain_sin  in  32  sin from result_converter, valid with chain_done
- chain_cos  in  32  cos from result_converter, valid with chain_done
- busy  out  1  high in every state except IDLE
- grant_id  out  1  requester currently owning the chain
- jobs_done  out  CNT_W  completed jobs, errors included
- timeouts  out  CNT_W  aborted jobs

Behaviour:
- Reset values:
  - State IDLE.
  - All outputs 0, except internal last_grant = 1, so requester 0 wins first.
  - Counters 0; timer 0; latched angle 0.
  - Reset mid-job abandons the job silently: no response, no counter update.
- States: IDLE, ISSUE, WAIT, RESPOND.
- IDLE:
  - If no req_valid bit is set, stay in IDLE.
  - Otherwise pick g with round-robin: if both bits are set, g = ~last_grant; else g = the set bit.
  - Same cycle: latch angle of g into norm_angle, set grant_id=g, pulse req_ready[g] for exactly one cycle, go to ISSUE.
- ISSUE:
  - Drive norm_valid=1.
  - If norm_ready=1 this cycle: go to WAIT, timer=0, norm_valid drops next cycle. norm_valid is therefore high ≥1 cycle.
  - If norm_ready=0: hold norm_valid and stay. No timeout applies in ISSUE.
- WAIT:
  - norm_valid=0; timer increments each cycle.
  - If chain_done=1: capture chain_sin/chain_cos into rsp_sin/rsp_cos, rsp_err=0, go to RESPOND.
  - Else if timer == TIMEOUT-1: rsp_sin=rsp_cos=0, rsp_err=1, timeouts+1, go to RESPOND.
  - chain_done in the same cycle as the timeout: done wins, no error.
- RESPOND:
  - rsp_valid[g]=1; data and rsp_err held stable.
  - When rsp_ready[g]=1: rsp_valid→0 next cycle, jobs_done+1, last_grant=g, go to IDLE.
  - rsp_ready of the non-granted requester is ignored.
  - chain_done arriving outside WAIT (late pulse after a timeout) is ignored.
- Counters saturate at all-ones; no wrap.
- req_valid bits are not required to stay asserted. A requester that drops valid before being granted loses its turn; nothing is latched for it.
- Minimum job latency: accept→rsp_valid = 3 cycles + chain latency. IDLE→ISSUE 1, ISSUE→WAIT 1, WAIT captures on done, RESPOND next.
- One job in flight at a time; no queueing.

Test Plan:
- Single job: req0 angle 0x41F00000 (30.0), norm_ready=1, stub chain returns done after 10 cycles with sin=0x3F000000, cos=0x3F5DB3D7 → req_ready=01 one cycle; norm_valid high exactly 1 cycle carrying 0x41F00000; rsp_valid=01 with those values, rsp_err=0; jobs_done=1.
- Fairness: both req_valid held high for 4 jobs → grant order 0,1,0,1; rsp_valid is one-hot and matches the grant each time.
- Timeout: TIMEOUT=8, chain never returns done → rsp_err=1 with rsp_sin=rsp_cos=0, exactly 8 cycles after WAIT entry; timeouts=1, jobs_done=1. A late chain_done afterwards → no effect.
- Race: chain_done asserted in the timer==TIMEOUT-1 cycle → rsp_err=0, data captured, timeouts unchanged.
- Backpressure: norm_ready=0 for 5 cycles → norm_valid held 6 cycles. rsp_ready[g]=0 for 7 cycles → rsp_valid and data stable; rsp_ready of the other requester has no effect.
- Reset mid-WAIT: assert rst → busy=0, rsp_valid=0, counters 0, next grant goes to requester 0.

Source files
------------

// File: rtl/trig_request_arbiter_if.sv
// Requester, response and chain-side signals of the trig request arbiter.
// The arbiter connects through the slave modport; requesters and the chain stub use master.
interface trig_request_arbiter_if;
    logic [1:0]  req_valid;
    logic [31:0] req0_angle;
    logic [31:0] req1_angle;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [31:0] rsp_sin;
    logic [31:0] rsp_cos;
    logic        rsp_err;
    logic        norm_valid;
    logic [31:0] norm_angle;
    logic        norm_ready;
    logic        chain_done;
    logic [31:0] chain_sin;
    logic [31:0] chain_cos;

    modport slave (
        input  req_valid, req0_angle, req1_angle, rsp_ready,
        input  norm_ready, chain_done, chain_sin, chain_cos,
        output req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err,
        output norm_valid, norm_angle
    );

    modport master (
        output req_valid, req0_angle, req1_angle, rsp_ready,
        output norm_ready, chain_done, chain_sin, chain_cos,
        input  req_ready, rsp_valid, rsp_sin, rsp_cos, rsp_err,
        input  norm_valid, norm_angle
    );
endinterface

// File: rtl/trig_request_arbiter.sv
// Round-robin arbiter sharing one normalizer/cordic/converter chain between two
// requesters, with a WAIT-state watchdog and saturating job/timeout counters.
module trig_request_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    trig_request_arbiter_if.slave bus,
    output logic                 busy,
    output logic                 grant_id,
    output logic [CNT_W-1:0]     jobs_done,
    output logic [CNT_W-1:0]     timeouts
);

    localparam int TIMER_W = $clog2(TIMEOUT);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESPOND = 2'd3
    } state_t;

    state_t             state_reg, state_next;
    logic               grant_reg, grant_next;
    logic               last_grant_reg, last_grant_next;
    logic [31:0]        angle_reg, angle_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [31:0]        sin_reg, sin_next;
    logic [31:0]        cos_reg, cos_next;
    logic               err_reg, err_next;
    logic [CNT_W-1:0]   jobs_reg, jobs_next;
    logic [CNT_W-1:0]   tmo_reg, tmo_next;

    logic               pick;
    logic [1:0]         req_ready_w;
    logic [1:0]         rsp_valid_w;

    // With both requesters pending, the one not served last wins.
    assign pick = (bus.req_valid == 2'b11) ? ~last_grant_reg : bus.req_valid[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            angle_reg      <= '0;
            timer_reg      <= '0;
            sin_reg        <= '0;
            cos_reg        <= '0;
            err_reg        <= 1'b0;
            jobs_reg       <= '0;
            tmo_reg        <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            last_grant_reg <= last_grant_next;
            angle_reg      <= angle_next;
            timer_reg      <= timer_next;
            sin_reg        <= sin_next;
            cos_reg        <= cos_next;
            err_reg        <= err_next;
            jobs_reg       <= jobs_next;
            tmo_reg        <= tmo_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        last_grant_next = last_grant_reg;
        angle_next      = angle_reg;
        timer_next      = timer_reg;
        sin_next        = sin_reg;
        cos_next        = cos_reg;
        err_next        = err_reg;
        jobs_next       = jobs_reg;
        tmo_next        = tmo_reg;

        case (state_reg)
            IDLE: begin
                if (|bus.req_valid) begin
                    grant_next = pick;
                    angle_next = pick ? bus.req1_angle : bus.req0_angle;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.norm_ready) begin
                    timer_next = '0;
                    state_next = WAIT;
                end
            end
            WAIT: begin
                // A done pulse in the final watchdog cycle still counts as success.
                if (bus.chain_done) begin
                    sin_next   = bus.chain_sin;
                    cos_next   = bus.chain_cos;
                    err_next   = 1'b0;
                    state_next = RESPOND;
                end else if (timer_reg == TIMER_LAST) begin
                    sin_next   = '0;
                    cos_next   = '0;
                    err_next   = 1'b1;
                    tmo_next   = (&tmo_reg) ? tmo_reg : tmo_reg + CNT_W'(1);
                    state_next = RESPOND;
                end else begin
                    timer_next = timer_reg + TIMER_W'(1);
                end
            end
            RESPOND: begin
                if (bus.rsp_ready[grant_reg]) begin
                    jobs_next       = (&jobs_reg) ? jobs_reg : jobs_reg + CNT_W'(1);
                    last_grant_next = grant_reg;
                    state_next      = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_port
        assign req_ready_w[gi] = (state_reg == IDLE) && bus.req_valid[gi] && (pick == 1'(gi));
        assign rsp_valid_w[gi] = (state_reg == RESPOND) && (grant_reg == 1'(gi));
    end

    assign bus.req_ready  = req_ready_w;
    assign bus.rsp_valid  = rsp_valid_w;
    assign bus.rsp_sin    = sin_reg;
    assign bus.rsp_cos    = cos_reg;
    assign bus.rsp_err    = err_reg;
    assign bus.norm_valid = (state_reg == ISSUE);
    assign bus.norm_angle = angle_reg;

    assign busy      = (state_reg != IDLE);
    assign grant_id  = grant_reg;
    assign jobs_done = jobs_reg;
    assign timeouts  = tmo_reg;

endmodule
